// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response,
// decode handshake and core redirect.
interface fetch_unit_if #(
   parameter int ADRS_W = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADRS_W-1:0] imem_req_adrs;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [ADRS_W-1:0] inst_pc;
   logic              redirect;
   logic [ADRS_W-1:0] redirect_adrs;

   modport master (
      output imem_req_valid,
      output imem_req_adrs,
      output inst_valid,
      output inst,
      output inst_pc,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      input  inst_ready,
      input  redirect,
      input  redirect_adrs
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_adrs,
      input  inst_valid,
      input  inst,
      input  inst_pc,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      output inst_ready,
      output redirect,
      output redirect_adrs
   );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: pipelined imem requests,
// prefetch queue, j predecode and redirect flush.
module fetch_unit #(
   parameter int                ADRS_W     = 32,
   parameter logic [ADRS_W-1:0] START_ADRS = '0,
   parameter int                QDEPTH     = 4,
   parameter int                MAX_OUT    = 2
) (
   input logic          clk_cpu,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + MAX_OUT + 1);

   logic [ADRS_W-1:0] fetch_pc;
   logic [ADRS_W-1:0] rsp_pc;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     discard;
   logic [CW-1:0]     qcount;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [31:0]       q_inst [QDEPTH];
   logic [ADRS_W-1:0] q_pc   [QDEPTH];

   logic              is_j;
   logic              push;
   logic              pop;
   logic              jmp_hit;
   logic              credit;
   logic              room;
   logic              req_fire;
   logic [CW-1:0]     inflight_nxt;
   logic [ADRS_W-1:0] j_target;
   logic [ADRS_W-1:0] rdr_adrs;

   // Issue credit, response acceptance and j predecode.
   always_comb begin
      is_j     = bus.imem_rsp_data[31:26] == 6'b000010;
      push     = bus.imem_rsp_valid && (discard == '0)
                 && !bus.redirect;
      jmp_hit  = push && is_j;
      credit   = (inflight + qcount) < CW'(QDEPTH);
      room     = inflight < CW'(MAX_OUT);
      bus.imem_req_valid = !reset && !bus.redirect
                           && !jmp_hit && credit && room;
      bus.imem_req_adrs  = fetch_pc;
      req_fire = bus.imem_req_valid && bus.imem_req_ready;
      bus.inst_valid = qcount != '0;
      bus.inst    = bus.inst_valid ? q_inst[rd_ptr] : '0;
      bus.inst_pc = bus.inst_valid ? q_pc[rd_ptr] : '0;
      pop      = bus.inst_valid && bus.inst_ready;
      inflight_nxt = inflight + CW'(req_fire)
                     - CW'(bus.imem_rsp_valid);
      j_target = {rsp_pc[ADRS_W-1:28],
                  bus.imem_rsp_data[25:0], 2'b00};
      rdr_adrs = bus.redirect_adrs & ~ADRS_W'(3);
   end

   // PCs, credit counters and queue pointers.
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         fetch_pc <= START_ADRS;
         rsp_pc   <= START_ADRS;
         inflight <= '0;
         discard  <= '0;
         qcount   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (bus.redirect) begin
            fetch_pc <= rdr_adrs;
            rsp_pc   <= rdr_adrs;
            discard  <= inflight_nxt;
            qcount   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            qcount <= qcount + CW'(push) - CW'(pop);
            if (jmp_hit) begin
               fetch_pc <= j_target;
               rsp_pc   <= j_target;
               discard  <= inflight_nxt;
            end else begin
               if (req_fire) fetch_pc <= fetch_pc + ADRS_W'(4);
               if (push) rsp_pc <= rsp_pc + ADRS_W'(4);
               else if (bus.imem_rsp_valid)
                  discard <= discard - CW'(1);
            end
         end
      end
   end

   // Queue storage; stale slots are masked by qcount.
   always_ff @(posedge clk_cpu) begin
      if (push) begin
         q_inst[wr_ptr] <= bus.imem_rsp_data;
         q_pc[wr_ptr]   <= rsp_pc;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an imem model and
// an expected-instruction scoreboard.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_unit_if #(.ADRS_W(32)) bus ();

   fetch_unit #(
      .ADRS_W(32), .START_ADRS(32'h0),
      .QDEPTH(4), .MAX_OUT(2)
   ) dut (
      .clk_cpu(clk),
      .reset(reset),
      .bus(bus.master)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_pc[$];
   logic [31:0] sb_inst[$];
   logic [31:0] pend_a[$];
   int          pend_t[$];
   logic [31:0] pc_log[$];
   logic [31:0] j_adrs = 32'hFFFF_FFFF;
   logic [31:0] j_tgt = 32'h0;
   logic [31:0] rsp_adrs = 32'h0;
   int  cyc_n = 0;
   int  lat = 1;
   int  pops = 0;
   int  n;
   int  idx;
   int  pb;
   logic watch_24 = 1'b0;
   logic seen_24 = 1'b0;

   function automatic logic [31:0] word(input logic [31:0] a);
      if (a == j_adrs) return {6'b000010, j_tgt[27:2]};
      return 32'h1000_0000 | a;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic cyc();
      logic fire, pop, rv, rdr, rst;
      logic [31:0] fa, ppc, pinst, ra, e;
      int k;
      #2;
      fire  = bus.imem_req_valid && bus.imem_req_ready;
      fa    = bus.imem_req_adrs;
      pop   = bus.inst_valid && bus.inst_ready;
      ppc   = bus.inst_pc;
      pinst = bus.inst;
      rv    = bus.imem_rsp_valid;
      ra    = rsp_adrs;
      rdr   = bus.redirect;
      rst   = reset;
      @(posedge clk);
      #1;
      cyc_n++;
      if (pop) begin
         pops++;
         pc_log.push_back(ppc);
         if (watch_24 && ppc == 32'h24) seen_24 = 1'b1;
         if (sb_pc.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL pop_unexpected: observed %h expected none",
                   ppc);
         end else begin
            e = sb_pc.pop_front();
            chk("pop_pc", ppc, e);
            e = sb_inst.pop_front();
            chk("pop_inst", pinst, e);
         end
      end
      if (rst) begin
         sb_pc.delete();
         sb_inst.delete();
         pend_a.delete();
         pend_t.delete();
         bus.imem_rsp_valid = 1'b0;
         return;
      end
      if (rdr) begin
         sb_pc.delete();
         sb_inst.delete();
      end else if (rv && ra == j_adrs) begin
         k = -1;
         foreach (sb_pc[i]) if (sb_pc[i] == ra) k = i;
         if (k >= 0)
            while (sb_pc.size() > k + 1) begin
               void'(sb_pc.pop_back());
               void'(sb_inst.pop_back());
            end
      end
      if (fire) begin
         pend_a.push_back(fa);
         pend_t.push_back(cyc_n);
         sb_pc.push_back(fa);
         sb_inst.push_back(word(fa));
      end
      if (pend_a.size() > 0 && cyc_n - pend_t[0] >= lat - 1) begin
         rsp_adrs = pend_a.pop_front();
         void'(pend_t.pop_front());
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = word(rsp_adrs);
      end else begin
         bus.imem_rsp_valid = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.inst_ready     = 1'b0;
      bus.redirect       = 1'b0;
      bus.redirect_adrs  = '0;
      cyc();
      cyc();
      chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
      chk("rst_req_adrs", bus.imem_req_adrs, 0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 0);
      chk("rst_inst", bus.inst, 0);
      chk("rst_inst_pc", bus.inst_pc, 0);

      reset = 1'b0;
      bus.inst_ready = 1'b1;
      #1;
      chk("first_req_valid", 32'(bus.imem_req_valid), 1);
      chk("first_req_adrs", bus.imem_req_adrs, 0);
      n = 0;
      while (!bus.inst_valid && n < 20) begin cyc(); n++; end
      chk("fill_latency", n, 2);
      pops = 0;
      repeat (8) cyc();
      chk("flow_rate", pops, 8);

      bus.inst_ready = 1'b0;
      repeat (10) cyc();
      chk("stall_entries", sb_pc.size(), 4);
      chk("stall_no_req", 32'(bus.imem_req_valid), 0);
      chk("stall_no_pend", pend_a.size(), 0);
      chk("stall_valid", 32'(bus.inst_valid), 1);
      chk("stall_next_adrs", bus.imem_req_adrs,
          sb_pc[3] + 32'd4);
      bus.inst_ready = 1'b1;
      repeat (8) cyc();

      lat = 2;
      repeat (4) cyc();
      bus.redirect = 1'b1;
      bus.redirect_adrs = 32'h100;
      #1;
      chk("rdr_req_low", 32'(bus.imem_req_valid), 0);
      pb = pops;
      cyc();
      chk("rdr_pop_once", pops - pb, 1);
      bus.redirect = 1'b0;
      n = 0;
      while (!bus.inst_valid && n < 20) begin cyc(); n++; end
      chk("rdr_first_pc", bus.inst_pc, 32'h100);
      repeat (6) cyc();

      j_adrs = 32'h20;
      j_tgt  = 32'h100;
      bus.redirect = 1'b1;
      bus.redirect_adrs = 32'h20;
      cyc();
      bus.redirect = 1'b0;
      pc_log.delete();
      watch_24 = 1'b1;
      repeat (14) cyc();
      watch_24 = 1'b0;
      idx = -1;
      foreach (pc_log[i]) if (pc_log[i] == 32'h20) idx = i;
      chk("j_delivered", 32'(idx >= 0), 1);
      if (idx >= 0 && idx + 1 < pc_log.size())
         chk("j_next_pc", pc_log[idx+1], 32'h100);
      else
         chk("j_next_pc", 32'hFFFF_FFFF, 32'h100);
      chk("j_skip_24", 32'(seen_24), 0);

      j_adrs = 32'h40;
      j_tgt  = 32'h300;
      bus.redirect = 1'b1;
      bus.redirect_adrs = 32'h40;
      cyc();
      bus.redirect = 1'b0;
      n = 0;
      while (!(bus.imem_rsp_valid && rsp_adrs == 32'h40)
             && n < 20) begin
         cyc();
         n++;
      end
      chk("j_rsp_seen", 32'(n < 20), 1);
      bus.redirect = 1'b1;
      bus.redirect_adrs = 32'h203;
      #1;
      chk("rdrj_req_low", 32'(bus.imem_req_valid), 0);
      cyc();
      bus.redirect = 1'b0;
      pc_log.delete();
      repeat (12) cyc();
      if (pc_log.size() > 0)
         chk("rdrj_first_pc", pc_log[0], 32'h200);
      else
         chk("rdrj_first_pc", 32'hFFFF_FFFF, 32'h200);

      bus.inst_ready = 1'b0;
      repeat (10) cyc();
      chk("pre_rst_full", sb_pc.size(), 4);
      reset = 1'b1;
      cyc();
      chk("mid_rst_inst_valid", 32'(bus.inst_valid), 0);
      chk("mid_rst_req_adrs", bus.imem_req_adrs, 0);
      chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_req_valid", 32'(bus.imem_req_valid), 1);
      chk("post_rst_req_adrs", bus.imem_req_adrs, 0);
      bus.inst_ready = 1'b1;
      pc_log.delete();
      repeat (10) cyc();
      if (pc_log.size() > 0)
         chk("post_rst_first_pc", pc_log[0], 32'h0);
      else
         chk("post_rst_first_pc", 32'hFFFF_FFFF, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
